// File: rtl/dbus_bridge.sv
// dbus_bridge: turns one memory-stage dbus request into a single valid/ready memory transaction,
// with natural-alignment checking and a watchdog that forces an error completion.
module dbus_bridge #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dreq_valid,
    input  logic [63:0] dreq_addr,
    input  logic [2:0]  dreq_size,
    input  logic [7:0]  dreq_strobe,
    input  logic [63:0] dreq_data,
    output logic        dresp_addr_ok,
    output logic        dresp_data_ok,
    output logic [63:0] dresp_data,
    output logic        mreq_valid,
    input  logic        mreq_ready,
    output logic [63:0] mreq_addr,
    output logic        mreq_we,
    output logic [7:0]  mreq_strobe,
    output logic [63:0] mreq_wdata,
    input  logic        mresp_valid,
    input  logic [63:0] mresp_rdata,
    output logic        misalign_err,
    output logic        timeout_err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
    state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_inc;
    logic skip, aligned, start, busy, done, expired;
    always_comb begin
        aligned = dreq_size == 3'd0 ? 1'b1 :
                  dreq_size == 3'd1 ? !dreq_addr[0] :
                  dreq_size == 3'd2 ? dreq_addr[1:0] == 2'b0 : dreq_addr[2:0] == 3'b0;
        // skip masks the cycle right after RESP, before the upstream clear is visible
        start   = state == IDLE && dreq_valid && !skip;
        busy    = state == REQ || state == WAIT;
        cnt_inc = &cnt ? cnt : cnt + 1'b1;
        done    = ((state == REQ && mreq_ready) || state == WAIT) && mresp_valid;
        expired = busy && !done && cnt_inc == LIMIT;
        state_n = state;
        unique case (state)
            IDLE:    state_n = start ? (aligned ? REQ : RESP) : IDLE;
            REQ:     state_n = done || expired ? RESP : mreq_ready ? WAIT : REQ;
            WAIT:    state_n = done || expired ? RESP : WAIT;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            skip          <= 1'b0;
            cnt           <= '0;
            mreq_valid    <= 1'b0;
            mreq_addr     <= '0;
            mreq_we       <= 1'b0;
            mreq_strobe   <= '0;
            mreq_wdata    <= '0;
            dresp_addr_ok <= 1'b0;
            dresp_data_ok <= 1'b0;
            dresp_data    <= '0;
            misalign_err  <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            state         <= state_n;
            skip          <= state == RESP;
            cnt           <= start ? '0 : busy ? cnt_inc : cnt;
            mreq_valid    <= state_n == REQ;
            dresp_addr_ok <= state_n == RESP;
            dresp_data_ok <= state_n == RESP;
            misalign_err  <= start && !aligned;
            if (start) begin
                mreq_addr   <= {dreq_addr[63:3], 3'b000};
                mreq_we     <= |dreq_strobe;
                mreq_strobe <= dreq_strobe;
                mreq_wdata  <= dreq_data;
            end
            if (start && !aligned)
                dresp_data <= '0;
            else if (done)
                dresp_data <= mreq_we ? 64'h0 : mresp_rdata;
            else if (expired)
                dresp_data <= '1;
            if (expired)
                timeout_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dbus_bridge.sv
// tb_dbus_bridge: directed requests from a memory-stage driver, a memory responder, and a
// scoreboard monitor comparing every ack and every memory request against queued expectations.
module tb_dbus_bridge;
    localparam logic [2:0] MSIZE1 = 3'd0, MSIZE2 = 3'd1, MSIZE4 = 3'd2, MSIZE8 = 3'd3;

    typedef struct packed {
        logic [63:0] addr;
        logic        we;
        logic [7:0]  strobe;
        logic [63:0] wdata;
        logic [63:0] rdata;
    } mtxn_t;
    typedef struct packed {
        logic [63:0] data;
        logic        mis;
    } resp_t;

    logic        clk = 1'b0, reset = 1'b1;
    logic        dreq_valid;
    logic [63:0] dreq_addr, dreq_data;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic        dresp_addr_ok, dresp_data_ok, misalign_err, timeout_err;
    logic [63:0] dresp_data;
    logic        mreq_valid, mreq_ready, mreq_we, mresp_valid;
    logic [63:0] mreq_addr, mreq_wdata, mresp_rdata;
    logic [7:0]  mreq_strobe;

    mtxn_t exp_mq[$];
    resp_t exp_rq[$];
    int    checks = 0, fails = 0, n_txn = 0;
    int    ready_delay = 0, resp_delay = 1, poke_req = 0, poke_done = 0;
    bit    mute = 1'b0;

    dbus_bridge #(.TIMEOUT_CYCLES(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .mreq_valid(mreq_valid), .mreq_ready(mreq_ready), .mreq_addr(mreq_addr),
        .mreq_we(mreq_we), .mreq_strobe(mreq_strobe), .mreq_wdata(mreq_wdata),
        .mresp_valid(mresp_valid), .mresp_rdata(mresp_rdata),
        .misalign_err(misalign_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // memory responder: accepts after ready_delay cycles, answers resp_delay cycles after accept
    initial begin
        mtxn_t m, c;
        mreq_ready  = 1'b0;
        mresp_valid = 1'b0;
        mresp_rdata = '0;
        forever begin
            @(negedge clk);
            if (poke_req != poke_done) begin
                mresp_valid = 1'b1;
                mresp_rdata = 64'h5555_5555_5555_5555;
                @(negedge clk);
                mresp_valid = 1'b0;
                poke_done   = poke_req;
            end else if (mreq_valid && !reset) begin
                c = '{mreq_addr, mreq_we, mreq_strobe, mreq_wdata, 64'h0};
                n_txn++;
                if (exp_mq.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected mreq: addr %0h we %0b", mreq_addr, mreq_we);
                    m = c;
                end else begin
                    m = exp_mq.pop_front();
                    check("mreq fields", {c.addr, c.we, c.strobe, c.wdata}, {m.addr, m.we, m.strobe, m.wdata});
                end
                for (int i = 0; i < ready_delay; i++) begin
                    @(negedge clk);
                    check("mreq hold", {mreq_valid, mreq_addr, mreq_we, mreq_strobe, mreq_wdata},
                          {1'b1, c.addr, c.we, c.strobe, c.wdata});
                end
                mreq_ready = 1'b1;
                if (!mute && resp_delay == 0) begin
                    mresp_valid = 1'b1;
                    mresp_rdata = m.rdata;
                end
                @(negedge clk);
                mreq_ready  = 1'b0;
                mresp_valid = 1'b0;
                check("mreq drop", mreq_valid, 1'b0);
                if (!mute && resp_delay > 0) begin
                    repeat (resp_delay - 1) @(negedge clk);
                    mresp_valid = 1'b1;
                    mresp_rdata = m.rdata;
                    @(negedge clk);
                    mresp_valid = 1'b0;
                end
            end
        end
    end

    // scoreboard monitor for the dresp side
    initial begin
        resp_t r;
        bit prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (dresp_addr_ok) begin
                    check("ack single", prev_ack, 1'b0);
                    if (exp_rq.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected ack: data %0h", dresp_data);
                    end else begin
                        r = exp_rq.pop_front();
                        check("dresp", {dresp_data_ok, misalign_err, dresp_data}, {1'b1, r.mis, r.data});
                    end
                end else if (dresp_data_ok || misalign_err)
                    check("stray pulse", {dresp_data_ok, misalign_err}, 2'b00);
            end
            prev_ack = dresp_addr_ok;
        end
    end

    task automatic do_req(input logic [63:0] addr, input logic [2:0] size, input logic [7:0] strobe,
                          input logic [63:0] wdata, input logic [63:0] rdata, input bit mis,
                          input bit late, input int lat);
        resp_t r;
        int    n;
        bit    got;
        r.mis  = mis;
        r.data = mis ? 64'h0 : mute ? '1 : (strobe != 8'h0) ? 64'h0 : rdata;
        exp_rq.push_back(r);
        if (!mis) exp_mq.push_back('{{addr[63:3], 3'b000}, strobe != 8'h0, strobe, wdata, rdata});
        dreq_valid  = 1'b1;
        dreq_addr   = addr;
        dreq_size   = size;
        dreq_strobe = strobe;
        dreq_data   = wdata;
        n   = 0;
        got = 1'b0;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            got = dresp_addr_ok;
        end
        if (!got) begin
            checks++;
            fails++;
            $display("FAIL ack wait: no ack for addr %0h after %0d cycles", addr, n);
        end else if (lat >= 0)
            check("latency", n, lat);
        // late upstream clear: old request stays visible through the IDLE cycle after RESP
        if (late) repeat (2) @(negedge clk);
        dreq_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL global time limit reached");
        $fatal(1);
    end

    initial begin
        dreq_valid  = 1'b0;
        dreq_addr   = '0;
        dreq_size   = MSIZE1;
        dreq_strobe = '0;
        dreq_data   = '0;
        repeat (3) @(negedge clk);
        check("reset state", {mreq_valid, mreq_addr, mreq_we, mreq_strobe, mreq_wdata, dresp_addr_ok,
              dresp_data_ok, dresp_data, misalign_err, timeout_err}, '0);
        reset = 1'b0;
        @(negedge clk);
        do_req(64'h8000_1008, MSIZE8, 8'h00, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b0, 3);
        ready_delay = 3;
        do_req(64'h8000_0003, MSIZE1, 8'h08, 64'hAB00_0000, 64'h0, 1'b0, 1'b0, 6);
        ready_delay = 0;
        do_req(64'h8000_0002, MSIZE4, 8'h00, 64'h0, 64'h0, 1'b1, 1'b0, 1);
        do_req(64'h8000_0006, MSIZE2, 8'h00, 64'h0, 64'h1122_3344_5566_7788, 1'b0, 1'b0, 3);
        do_req(64'h8000_0005, MSIZE2, 8'h00, 64'h0, 64'h0, 1'b1, 1'b0, 1);
        resp_delay = 3;
        do_req(64'h8000_0004, MSIZE4, 8'h00, 64'h0, 64'h0BAD_F00D_1234_5678, 1'b0, 1'b0, 5);
        resp_delay = 1;
        do_req(64'h8000_0004, MSIZE8, 8'h00, 64'h0, 64'h0, 1'b1, 1'b0, 1);
        resp_delay = 0;
        do_req(64'h8000_0040, MSIZE8, 8'h00, 64'h0, 64'h0102_0304_0506_0708, 1'b0, 1'b0, 2);
        resp_delay = 1;
        mute = 1'b1;
        do_req(64'h8000_4000, MSIZE8, 8'h00, 64'h0, 64'h0, 1'b0, 1'b0, 9);
        mute = 1'b0;
        check("timeout sticky set", timeout_err, 1'b1);
        poke_req++;
        repeat (4) @(negedge clk);
        do_req(64'h8000_2000, MSIZE8, 8'h00, 64'h0, 64'hA5A5_0000_FFFF_1234, 1'b0, 1'b1, 3);
        do_req(64'h8000_2008, MSIZE8, 8'hFF, 64'h1357_9BDF_0246_8ACE, 64'h0, 1'b0, 1'b0, 3);
        check("timeout sticky held", timeout_err, 1'b1);
        mute = 1'b1;
        exp_mq.push_back('{64'h8000_3000, 1'b0, 8'h00, 64'h0, 64'h0});
        dreq_valid  = 1'b1;
        dreq_addr   = 64'h8000_3000;
        dreq_size   = MSIZE8;
        dreq_strobe = 8'h00;
        dreq_data   = 64'h0;
        repeat (3) @(negedge clk);
        check("in wait", {mreq_valid, dresp_addr_ok}, 2'b00);
        reset      = 1'b1;
        dreq_valid = 1'b0;
        @(negedge clk);
        check("reset mid txn", {mreq_valid, mreq_addr, mreq_we, mreq_strobe, mreq_wdata, dresp_addr_ok,
              dresp_data_ok, dresp_data, misalign_err, timeout_err}, '0);
        reset = 1'b0;
        mute  = 1'b0;
        @(negedge clk);
        do_req(64'h8000_5010, MSIZE8, 8'h00, 64'h0, 64'hFEED_FACE_0000_0001, 1'b0, 1'b0, 3);
        repeat (3) @(negedge clk);
        check("txn count", n_txn, 10);
        check("pending acks", exp_rq.size(), 0);
        check("pending mreq", exp_mq.size(), 0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
